moving_sum3_inverse: RTL and testbench

MOVING_SUM3_INVERSE -- requirements
Module: moving_sum3_inverse

---
 rtl/moving_sum3_inverse_pkg.sv | 13 +
 rtl/moving_sum3_inverse_range.sv | 28 ++
 rtl/moving_sum3_inverse.sv | 100 ++++++++++
 tb/tb_moving_sum3_inverse.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/moving_sum3_inverse_pkg.sv
// Shared definitions for the 3-tap moving-sum inverse: FSM states and the default sample width.
package moving_sum3_inverse_pkg;

   localparam int DATA_W_DEFAULT = 8;

   // Priming sequence: the first two samples have fewer than two predecessors.
   typedef enum logic [1:0] {
      PRIME0 = 2'd0,
      PRIME1 = 2'd1,
      RUN    = 2'd2
   } state_t;

endpackage

// File: rtl/moving_sum3_inverse_range.sv
// Range handling for a reconstructed sample: flags values outside the DATA_W signed range,
// then either clamps them (MOVING_SUM3_INVERSE_SAT_EN defined) or wraps them (default build).
module moving_sum3_inverse_range #(
   parameter int DATA_W = 8,
   parameter int IN_W   = DATA_W + 3
) (
   input  logic signed [IN_W-1:0]   value,
   output logic signed [DATA_W-1:0] result,
   output logic                     out_of_range
);

   // Largest and smallest representable DATA_W values, sign-extended to the input width.
   localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   // Detect overflow and pick the stored/output value; the flag is the same in both builds.
   always_comb begin
      out_of_range = (value > MAX_V) || (value < MIN_V);
      result       = value[DATA_W-1:0];
`ifdef MOVING_SUM3_INVERSE_SAT_EN
      if (value > MAX_V)
         result = MAX_V[DATA_W-1:0];
      else if (value < MIN_V)
         result = MIN_V[DATA_W-1:0];
`endif
   end

endmodule

// File: rtl/moving_sum3_inverse.sv
// Inverse of a 3-tap moving sum: x[n] = y[n] - x[n-1] - x[n-2], with a one-deep output
// register and valid/ready handshakes. Optional clamping via MOVING_SUM3_INVERSE_SAT_EN.
module moving_sum3_inverse
   import moving_sum3_inverse_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEFAULT,
   localparam int SUM_W  = DATA_W + 2
) (
   input  logic                     system1000,
   input  logic                     system1000_rstn,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [SUM_W-1:0]  in_sum,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   input  logic                     out_ready,
   output logic                     sat_flag
);

   localparam int EXT = SUM_W + 1 - DATA_W;

   state_t                    state, state_next;
   logic signed [DATA_W-1:0]  h0, h1, res;
   logic signed [SUM_W:0]     y_ext, h0_ext, h1_ext, diff;
   logic                      ovf, accept;

   // Output register frees up when empty or being read; clear blocks new input that cycle.
   assign in_ready = (!out_valid || out_ready) && !clear;
   assign accept   = in_valid && in_ready;

   assign y_ext  = {in_sum[SUM_W-1], in_sum};
   assign h0_ext = {{EXT{h0[DATA_W-1]}}, h0};
   assign h1_ext = {{EXT{h1[DATA_W-1]}}, h1};

   // Subtract only the history that exists so far; one extra bit avoids overflow.
   always_comb begin
      diff = y_ext;
      case (state)
         PRIME1:  diff = y_ext - h0_ext;
         RUN:     diff = y_ext - h0_ext - h1_ext;
         default: diff = y_ext;
      endcase
   end

   moving_sum3_inverse_range #(.DATA_W(DATA_W), .IN_W(SUM_W + 1)) u_range (
      .value        (diff),
      .result       (res),
      .out_of_range (ovf)
   );

   // Next state: clear re-primes, each accepted sample advances one step.
   always_comb begin
      state_next = state;
      if (clear)
         state_next = PRIME0;
      else if (accept) begin
         case (state)
            PRIME0:  state_next = PRIME1;
            PRIME1:  state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   // State register.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn)
         state <= PRIME0;
      else
         state <= state_next;
   end

   // History, output register and sticky flag; a pending output still drains during clear.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         h0        <= '0;
         h1        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (clear) begin
            h0       <= '0;
            h1       <= '0;
            sat_flag <= 1'b0;
         end else if (accept) begin
            out_data  <= res;
            out_valid <= 1'b1;
            h1        <= h0;
            h0        <= res;
            if (ovf)
               sat_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_moving_sum3_inverse.sv
// Bench for moving_sum3_inverse: queue-based reference model checked every cycle,
// plus literal output sequences for the directed scenarios.
module tb_moving_sum3_inverse;

   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 clear = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW+1:0] in_sum = '0;
   logic                 out_ready = 1'b1;
   logic                 in_ready, out_valid, sat_flag;
   logic signed [DW-1:0] out_data;

   int tests = 0;
   int fails = 0;

   int exp_q[$];   // accepted results not yet delivered
   int hist[$];    // most recent reconstructed samples, newest first
   int got[$];     // delivered samples for literal checks
   bit m_sat = 1'b0;

   moving_sum3_inverse #(.DATA_W(DW)) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .clear           (clear),
      .in_valid        (in_valid),
      .in_sum          (in_sum),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .sat_flag        (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Range handling from the arithmetic definition: clamp or two's-complement wrap.
   function automatic int fit(input int v);
      int m, r;
`ifdef MOVING_SUM3_INVERSE_SAT_EN
      if (v > (1 << (DW-1)) - 1) return (1 << (DW-1)) - 1;
      if (v < -(1 << (DW-1)))    return -(1 << (DW-1));
      return v;
`else
      m = 1 << DW;
      r = ((v % m) + m) % m;
      if (r >= m / 2) r -= m;
      return r;
`endif
   endfunction

   // Reference model and per-cycle compare, evaluated mid-cycle when inputs are stable.
   always @(negedge clk) begin
      int v;
      bit m_ready;
      if (!rstn) begin
         exp_q.delete();
         hist.delete();
         m_sat = 1'b0;
      end else begin
         m_ready = (exp_q.size() == 0 || out_ready) && !clear;
         check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("out_data", int'(out_data), exp_q[0]);
         check("sat_flag", int'(sat_flag), int'(m_sat));
         check("in_ready", int'(in_ready), int'(m_ready));
         if (exp_q.size() != 0 && out_ready) begin
            got.push_back(int'(out_data));
            void'(exp_q.pop_front());
         end
         if (clear) begin
            hist.delete();
            m_sat = 1'b0;
         end else if (in_valid && m_ready) begin
            v = int'(in_sum);
            foreach (hist[i]) v -= hist[i];
            if (v > (1 << (DW-1)) - 1 || v < -(1 << (DW-1))) m_sat = 1'b1;
            v = fit(v);
            exp_q.push_back(v);
            hist.push_front(v);
            if (hist.size() > 2) void'(hist.pop_back());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_sum   = (DW+2)'(v);
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready && !clear;
         step();
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) step();
      check("drain_empty", int'(out_valid), 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic check_log(input string name, input int e[$]);
      check({name, "_count"}, got.size(), e.size());
      foreach (e[i]) if (i < got.size()) check(name, got[i], e[i]);
      got.delete();
   endtask

   initial begin
      int e[$];

      // Reset state
      step(); step();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_sat", int'(sat_flag), 0);
      rstn = 1'b1;

      // Continuous flow
      got.delete();
      send(1); send(3); send(6); send(9); send(12);
      drain();
      e = '{1, 2, 3, 4, 5};
      check_log("flow", e);

      // Back-pressure for three cycles after the first output
      do_clear();
      send(1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sum    = 10'sd3;
      step(); step(); step();
      check("stall_hold", int'(out_data), 1);
      check("stall_in_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      send(3); send(6); send(9); send(12);
      drain();
      e = '{1, 2, 3, 4, 5};
      check_log("stall", e);

      // Clear re-primes; the input coincident with clear is dropped
      do_clear();
      send(1); send(3); send(6);
      in_valid = 1'b1;
      in_sum   = 10'sd50;
      do_clear();
      in_valid = 1'b0;
      drain();
      send(5); send(9);
      drain();
      e = '{1, 2, 3, 5, 4};
      check_log("clear", e);

      // Positive overflow
      do_clear();
      send(300);
      drain();
`ifdef MOVING_SUM3_INVERSE_SAT_EN
      e = '{127};
`else
      e = '{44};
`endif
      check_log("ovf", e);
      check("ovf_sat", int'(sat_flag), 1);

      // Negative boundary without overflow
      do_clear();
      check("clear_sat", int'(sat_flag), 0);
      send(-128); send(-256); send(-384);
      drain();
      e = '{-128, -128, -128};
      check_log("neg", e);
      check("neg_sat", int'(sat_flag), 0);

      // Reset with an undelivered output
      out_ready = 1'b0;
      send(5);
      check("pre_rst_valid", int'(out_valid), 1);
      #1 rstn = 1'b0;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_data", int'(out_data), 0);
      step(); step();
      rstn = 1'b1;
      got.delete();
      out_ready = 1'b1;
      send(7);
      drain();
      e = '{7};
      check_log("post_rst", e);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
